// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing header: line/frame geometry, sync polarity and coordinate widths.
// Room renderers import the same constants for their wall bounds.
package vga_timing_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int CNT_W = 10;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
  } sync_t;

  // Value every delay stage holds while in reset: syncs inactive, picture blanked.
  localparam sync_t SYNC_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, bl: 1'b1};

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register that realigns hsync/vsync/blank with the registered room mapData.
// DEPTH=0 is a plain wire; every stage resets to the idle sync word.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  sync_t din,
  output sync_t dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_pipe
      sync_t stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: scan counters, saturated CurrentX/CurrentY, delayed sync/blank and frame_start.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_sync_gen #(
  parameter int PIPE_DLY = 1,
  parameter int H_VIS    = vga_timing_pkg::H_VIS,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_VIS    = vga_timing_pkg::V_VIS,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic                          clk_vga,
  input  logic                          rst_n,
  output logic [vga_timing_pkg::X_W-1:0] CurrentX,
  output logic [vga_timing_pkg::Y_W-1:0] CurrentY,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          blank,
  output logic                          frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]                   frame_cnt
`endif
);

  import vga_timing_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);
  localparam logic [X_W-1:0]   X_MAX    = X_W'(H_VIS - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(V_VIS - 1);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic [CNT_W-1:0] hcnt_nxt;
  logic [CNT_W-1:0] vcnt_nxt;
  logic             line_end;
  logic             frame_end;
  sync_t            sync_raw;
  sync_t            sync_dly;

  always_comb begin
    line_end  = (hcnt == H_LAST);
    frame_end = line_end && (vcnt == V_LAST);
    hcnt_nxt  = line_end ? '0 : hcnt + CNT_W'(1);
    vcnt_nxt  = vcnt;
    if (frame_end)     vcnt_nxt = '0;
    else if (line_end) vcnt_nxt = vcnt + CNT_W'(1);
  end

  // Coordinates are loaded from the next counter values so they change in the same cycle as the counters.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      CurrentX    <= '0;
      CurrentY    <= '0;
      frame_start <= 1'b0;
    end else begin
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      CurrentX    <= (hcnt_nxt < H_VIS_C) ? hcnt_nxt : X_MAX;
      CurrentY    <= (vcnt_nxt < V_VIS_C) ? vcnt_nxt[Y_W-1:0] : Y_MAX;
      frame_start <= frame_end;
    end
  end

  always_comb begin
    sync_raw.hs = in_window(hcnt, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    sync_raw.vs = in_window(vcnt, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    sync_raw.bl = (hcnt >= H_VIS_C) || (vcnt >= V_VIS_C);
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DLY)
  ) u_delay (
    .clk   (clk_vga),
    .rst_n (rst_n),
    .din   (sync_raw),
    .dout  (sync_dly)
  );

  assign hsync = sync_dly.hs;
  assign vsync = sync_dly.vs;
  assign blank = sync_dly.bl;

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk_vga) begin
    if (!rst_n)         frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a real 640x480 instance for line timing and a shrunken-geometry
// instance so whole frames, vertical saturation and mid-frame reset fit in a short run.
module tb_vga_sync_gen;

  // Full-size geometry, delay 1
  localparam int F_HT = 800, F_VT = 525, F_HV = 640, F_HFP = 16, F_HS = 96;
  localparam int F_VV = 480, F_VFP = 10, F_VS = 2, F_DLY = 1;
  // Shrunken geometry, delay 2: 16 x 11 -> 176 cycles per frame
  localparam int S_HT = 16, S_VT = 11, S_HV = 8, S_HFP = 2, S_HS = 3;
  localparam int S_VV = 6, S_VFP = 1, S_VS = 2, S_DLY = 2;
  localparam int S_FRAME = S_HT * S_VT;

  typedef struct packed {
    int x;
    int y;
    bit hs;
    bit vs;
    bit bl;
    bit fs;
    int fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstFull = 1'b0;
  logic       rstSmall = 1'b0;
  logic [9:0] fullX;
  logic [8:0] fullY;
  logic       fullHs, fullVs, fullBl, fullFs;
  logic [9:0] smallX;
  logic [8:0] smallY;
  logic       smallHs, smallVs, smallBl, smallFs;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fullFc, smallFc;
`endif

  int  errors = 0;
  int  checks = 0;
  int  tFull = 0;
  int  tSmall = 0;
  bit  runFull = 1'b0;
  bit  runSmall = 1'b0;

  always #20 clk = ~clk;

  vga_sync_gen #(
    .PIPE_DLY (F_DLY)
  ) u_full (
    .clk_vga     (clk),
    .rst_n       (rstFull),
    .CurrentX    (fullX),
    .CurrentY    (fullY),
    .hsync       (fullHs),
    .vsync       (fullVs),
    .blank       (fullBl),
    .frame_start (fullFs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt   (fullFc)
`endif
  );

  vga_sync_gen #(
    .PIPE_DLY (S_DLY),
    .H_VIS    (S_HV),
    .H_FP     (S_HFP),
    .H_SYNC   (S_HS),
    .H_BP     (3),
    .V_VIS    (S_VV),
    .V_FP     (S_VFP),
    .V_SYNC   (S_VS),
    .V_BP     (2)
  ) u_small (
    .clk_vga     (clk),
    .rst_n       (rstSmall),
    .CurrentX    (smallX),
    .CurrentY    (smallY),
    .hsync       (smallHs),
    .vsync       (smallVs),
    .blank       (smallBl),
    .frame_start (smallFs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt   (smallFc)
`endif
  );

  // Reference: outputs as a function of cycles elapsed since the last sampled reset
  function automatic exp_t model(input int ht, input int vt, input int hv, input int hfp,
                                 input int hsw, input int vv, input int vfp, input int vsw,
                                 input int dly, input int t);
    exp_t e;
    int h, v, td, hd, vd;
    h    = t % ht;
    v    = (t / ht) % vt;
    e.x  = (h < hv) ? h : hv - 1;
    e.y  = (v < vv) ? v : vv - 1;
    e.fs = (t > 0) && (t % (ht * vt) == 0);
    e.fc = (t / (ht * vt)) % 65536;
    td   = t - dly;
    if (td < 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bl = 1'b1;
    end else begin
      hd   = td % ht;
      vd   = (td / ht) % vt;
      e.hs = !((hd >= hv + hfp) && (hd < hv + hfp + hsw));
      e.vs = !((vd >= vv + vfp) && (vd < vv + vfp + vsw));
      e.bl = (hd >= hv) || (vd >= vv);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", name, actual, expected, $time);
      if (errors >= 200) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  endtask

  task automatic applyStimulus(input bit isSmall, input logic rstLevel, input int cycles);
    if (isSmall) rstSmall = rstLevel;
    else         rstFull  = rstLevel;
    repeat (cycles) @(negedge clk);
  endtask

  // Elapsed-cycle trackers; any sampled reset restarts the count at 0
  always @(posedge clk) begin
    if (!rstFull) begin
      tFull   <= 0;
      runFull <= 1'b1;
    end else if (runFull) begin
      tFull <= tFull + 1;
    end
    if (!rstSmall) begin
      tSmall   <= 0;
      runSmall <= 1'b1;
    end else if (runSmall) begin
      tSmall <= tSmall + 1;
    end
  end

  always @(negedge clk) begin
    exp_t ef, es;
    if (runFull) begin
      ef = model(F_HT, F_VT, F_HV, F_HFP, F_HS, F_VV, F_VFP, F_VS, F_DLY, tFull);
      checkOutput("full.CurrentX", int'(fullX), ef.x);
      checkOutput("full.CurrentY", int'(fullY), ef.y);
      checkOutput("full.hsync", int'(fullHs), int'(ef.hs));
      checkOutput("full.vsync", int'(fullVs), int'(ef.vs));
      checkOutput("full.blank", int'(fullBl), int'(ef.bl));
      checkOutput("full.frame_start", int'(fullFs), int'(ef.fs));
`ifdef VGA_FRAME_COUNT_EN
      checkOutput("full.frame_cnt", int'(fullFc), ef.fc);
`endif
    end
    if (runSmall) begin
      es = model(S_HT, S_VT, S_HV, S_HFP, S_HS, S_VV, S_VFP, S_VS, S_DLY, tSmall);
      checkOutput("small.CurrentX", int'(smallX), es.x);
      checkOutput("small.CurrentY", int'(smallY), es.y);
      checkOutput("small.hsync", int'(smallHs), int'(es.hs));
      checkOutput("small.vsync", int'(smallVs), int'(es.vs));
      checkOutput("small.blank", int'(smallBl), int'(es.bl));
      checkOutput("small.frame_start", int'(smallFs), int'(es.fs));
`ifdef VGA_FRAME_COUNT_EN
      checkOutput("small.frame_cnt", int'(smallFc), es.fc);
`endif
    end
  end

  initial begin
    int  fall0, fall1, rise0, fsA, fsB, vsFall, vsRise, gap, tgt;
    logic prevHs, prevVs;
    bit  found;

    // Reset held 5 cycles on the full-size instance
    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("reset_x", int'(fullX), 0);
    checkOutput("reset_y", int'(fullY), 0);
    checkOutput("reset_hsync", int'(fullHs), 1);
    checkOutput("reset_vsync", int'(fullVs), 1);
    checkOutput("reset_blank", int'(fullBl), 1);
    checkOutput("reset_frame_start", int'(fullFs), 0);
    applyStimulus(1'b0, 1'b1, 0);

    // Line timing and horizontal saturation
    fall0 = -1; fall1 = -1; rise0 = -1;
    prevHs = fullHs;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (tFull == 1)   checkOutput("release_blank", int'(fullBl), 0);
      if (tFull == 639) checkOutput("x_at_639", int'(fullX), 639);
      if (tFull == 640) checkOutput("blank_for_x639", int'(fullBl), 0);
      if (tFull == 700) checkOutput("x_sat_at_700", int'(fullX), 639);
      if (tFull == 701) checkOutput("blank_for_x700", int'(fullBl), 1);
      if (prevHs && !fullHs) begin
        if (fall0 < 0)      fall0 = tFull;
        else if (fall1 < 0) fall1 = tFull;
      end
      if (!prevHs && fullHs && fall0 >= 0 && rise0 < 0) rise0 = tFull;
      prevHs = fullHs;
    end
    checkOutput("hsync_first_fall", fall0, 657);
    checkOutput("hsync_period", fall1 - fall0, 800);
    checkOutput("hsync_low_len", rise0 - fall0, 96);

    // Shrunken instance: frame period, vsync width, vertical saturation
    applyStimulus(1'b1, 1'b1, 0);
    fsA = -1; fsB = -1; vsFall = -1; vsRise = -1;
    prevVs = smallVs;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tSmall == 87) begin
        checkOutput("small_x_last_vis", int'(smallX), 7);
        checkOutput("small_y_last_vis", int'(smallY), 5);
      end
      if (tSmall == 89) checkOutput("small_blank_last_vis", int'(smallBl), 0);
      if (tSmall == 99) begin
        checkOutput("small_x_in_vblank", int'(smallX), 3);
        checkOutput("small_y_sat", int'(smallY), 5);
        checkOutput("small_blank_vblank", int'(smallBl), 1);
      end
      if (smallFs) begin
        if (fsA < 0)      fsA = tSmall;
        else if (fsB < 0) fsB = tSmall;
      end
      if (prevVs && !smallVs && vsFall < 0) vsFall = tSmall;
      if (!prevVs && smallVs && vsFall >= 0 && vsRise < 0) vsRise = tSmall;
      prevVs = smallVs;
    end
    checkOutput("first_frame_start", fsA, 176);
    checkOutput("frame_period", fsB - fsA, 176);
    checkOutput("vsync_first_fall", vsFall, 114);
    checkOutput("vsync_low_len", vsRise - vsFall, 32);

    // Mid-frame reset at column 5, row 3 of the shrunken frame
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (tSmall % S_FRAME == 53) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("midframe_point_reached", int'(found), 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("midreset_x", int'(smallX), 0);
    checkOutput("midreset_y", int'(smallY), 0);
    checkOutput("midreset_frame_start", int'(smallFs), 0);
    applyStimulus(1'b1, 1'b1, 0);
    gap = -1;
    for (int n = 1; n <= 400 && gap < 0; n++) begin
      @(negedge clk);
      if (smallFs) gap = n;
    end
    checkOutput("frame_start_after_midreset", gap, 176);

`ifdef VGA_FRAME_COUNT_EN
    tgt = 3 * S_FRAME + 1;
    for (int i = 0; i < 600 && tSmall < tgt; i++) @(negedge clk);
    checkOutput("frame_cnt_after_3", int'(smallFc), 3);
`else
    tgt = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
